load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage that sits directly downstream of the ALU. It takes the ALU result as the effective address, issues one data-bus transaction per instruction, and returns load data aligned and sign/zero-extended for writeback. Stores use the same handshake and retire with a response carrying zero data.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: effective address width, equal to `RISCV_WORD_WIDTH`.

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `req_valid_i` input 1: core presents an access.
- `req_ready_o` output 1: unit accepts an access; high only in IDLE.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_size_i` input 2: access size; 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_unsigned_i` input 1: zero-extend the load (LBU/LHU).
- `req_addr_i` input 32: effective address, driven from the ALU result.
- `req_wdata_i` input 32: store data (rs2).
- `req_rd_i` input 5: destination register tag, returned unchanged.
- `rsp_valid_o` output 1: one-cycle pulse when the access is complete.
- `rsp_rdata_o` output 32: extended load data; 0 for stores and errors.
- `rsp_rd_o` output 5: tag of the completed access.
- `rsp_err_o` output 1: misaligned access; constant 0 when `LSU_MISALIGN_TRAP_EN` is not defined.
- `data_req_o` output 1: bus request.
- `data_gnt_i` input 1: bus grant.
- `data_addr_o` output 32: word-aligned address ({addr[31:2], 2'b00}).
- `data_we_o` output 1: bus write enable.
- `data_be_o` output 4: byte enables.
- `data_wdata_o` output 32: lane-replicated store data.
- `data_rvalid_i` input 1: bus response valid, for both reads and writes.
- `data_rdata_i` input 32: bus read data.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: when `req_valid_i` is high, register all request fields.
  - Normal access: go to REQ.
  - Misaligned access with trap enabled: stay in IDLE and issue the error response on the next cycle.
- REQ: `data_req_o` = 1, and all `data_*` outputs are held stable. When `data_gnt_i` is high, go to WAIT.
- WAIT: `data_req_o` = 0. When `data_rvalid_i` is high, capture the extracted data and go to IDLE. The next cycle drives `rsp_valid_o` = 1 for exactly one cycle.
- `data_rvalid_i` is ignored outside WAIT. `data_gnt_i` is ignored outside REQ.
- The response has no backpressure; the core must always accept it.
- Byte enables and store data:
  - Byte: `be` = 4'b0001 << a[1:0]; `wdata` = {4{wdata[7:0]}}.
  - Half: `be` = 4'b0011 << {a[1],1'b0}; `wdata` = {2{wdata[15:0]}}.
  - Word: `be` = 4'b1111; `wdata` passed through.
- Load extraction:
  - Shift `data_rdata_i` right by 8*a[1:0].
  - Byte/half: take bits [7:0] or [15:0], then sign-extend, or zero-extend when `req_unsigned_i` is set.
  - Word: no extension.
- Misaligned means half with a[0] = 1, or word with a[1:0] != 0.

## Timing
- Reset values: FSM = IDLE. `req_ready_o` = 1. `rsp_valid_o`, `rsp_err_o` and `data_req_o` = 0. `rsp_rdata_o`, `data_addr_o`, `data_be_o` and `data_wdata_o` = 0. `rsp_rd_o` = 0. `data_we_o` = 0.
- Latency: accept in cycle N, then `data_req_o` in N+1. With grant in N+1 and rvalid in N+2, `rsp_valid_o` is in N+3, so the minimum is 3 cycles.
- Grant may be delayed any number of cycles. `data_req_o` stays high and its payload is stable until grant.
- An rvalid in the same cycle as grant is not accepted. rvalid must arrive at least one cycle after grant.
- `req_ready_o` is high in the cycle `rsp_valid_o` is high, so accesses can run back-to-back. The next accept may occur in the response cycle.
- Reset mid-operation (REQ or WAIT): the unit returns to IDLE immediately. `data_req_o` drops, no response is produced, and a late rvalid is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access issues no bus request.
  - The cycle after accept: `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_rdata_o` = 0.
  - Stores are not performed.
- Not defined:
  - Low address bits are masked: a[0] is cleared for half, a[1:0] are cleared for word.
  - The access proceeds normally; `rsp_err_o` is tied to 0.

## Structure
- Size encodings (`LSU_SIZE_BYTE`, `LSU_SIZE_HALF`, `LSU_SIZE_WORD`) and FSM state encodings go in the shared include `lsu_defines.v`, alongside `riscv_defines.v`.
- One combinational sub-module, `lsu_data_align`: takes size, unsigned flag, a[1:0], store data and read data. It produces `be`, lane-replicated `wdata` and extended `rdata`. The FSM and registers stay in `load_store_unit`.

## Test plan
- LW at 0x100, grant immediate, rvalid with 0xDEADBEEF one cycle later → `data_be_o` = 4'hF, `rsp_rdata_o` = 0xDEADBEEF, `rsp_valid_o` at N+3.
- LB at 0x103, rdata 0x80FFFFFF → `data_be_o` = 4'b1000, `rsp_rdata_o` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, data 0x1234ABCD, grant delayed 3 cycles → `data_req_o` high for 4 cycles with stable payload, `data_be_o` = 4'b1100, `data_wdata_o` = 0xABCDABCD, `rsp_rdata_o` = 0.
- LW at 0x101 with the macro → no `data_req_o`, `rsp_err_o` = 1 the cycle after accept. Without the macro → `data_addr_o` = 0x100, normal load.
- Back-to-back: second request held valid during the first response → accepted in the response cycle, its `data_req_o` the next cycle.
- `rst_i` asserted in WAIT, then rvalid → `data_req_o` = 0, no `rsp_valid_o`, `req_ready_o` = 1.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared size/state encodings and helpers for the load/store unit
package load_store_unit_pkg;

    localparam int RISCV_WORD_WIDTH = 32;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    // Half needs a[0] clear, word needs a[1:0] clear; size 11 behaves as word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            LSU_SIZE_BYTE: mis = 1'b0;
            LSU_SIZE_HALF: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Natural-alignment mask of the low address bits for the given size.
    function automatic logic [1:0] lsu_align_offset(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] o;
        case (size)
            LSU_SIZE_BYTE: o = off;
            LSU_SIZE_HALF: o = {off[1], 1'b0};
            default:       o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-enable, store-lane replication and load extraction
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Bring the addressed lane down to bit 0 before extension.
    assign shifted = rdata_i >> {off_i, 3'b000};

    // Lane selection for stores and sign/zero extension for loads.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (size_i)
            LSU_SIZE_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            LSU_SIZE_HALF: begin
                be_o    = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage; optional misalignment trap via LSU_MISALIGN_TRAP_EN
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = RISCV_WORD_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic [4:0]            rsp_rd_o,
    output logic                  rsp_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i
);

    lsu_state_e            state_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic [4:0]            rd_q;
    logic                  data_req_q;
    logic                  data_we_q;
    logic [ADDR_WIDTH-1:0] data_addr_q;
    logic [3:0]            data_be_q;
    logic [31:0]           data_wdata_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic [4:0]            rsp_rd_q;

    logic                  idle;
    logic [1:0]            off_d;
    logic [1:0]            size_sel;
    logic                  uns_sel;
    logic [1:0]            off_sel;
    logic [3:0]            be_d;
    logic [31:0]           wdata_d;
    logic [31:0]           rdata_d;

    assign idle  = (state_q == LSU_IDLE);
    // Low bits forced to natural alignment; a trapped access never reaches the bus anyway.
    assign off_d = lsu_align_offset(req_size_i, req_addr_i[1:0]);

    // One aligner serves both directions: request fields while IDLE, captured fields afterwards.
    assign size_sel = idle ? req_size_i     : size_q;
    assign uns_sel  = idle ? req_unsigned_i : uns_q;
    assign off_sel  = idle ? off_d          : off_q;

    lsu_data_align u_align (
        .size_i     (size_sel),
        .unsigned_i (uns_sel),
        .off_i      (off_sel),
        .wdata_i    (req_wdata_i),
        .rdata_i    (data_rdata_i),
        .be_o       (be_d),
        .wdata_o    (wdata_d),
        .rdata_o    (rdata_d)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic rsp_err_q;
`endif

    // Access FSM: IDLE captures, REQ holds the bus payload until grant, WAIT collects rvalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= LSU_IDLE;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            rd_q         <= 5'd0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_addr_q  <= '0;
            data_be_q    <= 4'b0000;
            data_wdata_q <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_rd_q     <= 5'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
            case (state_q)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        size_q       <= req_size_i;
                        uns_q        <= req_unsigned_i;
                        off_q        <= off_d;
                        rd_q         <= req_rd_i;
                        data_we_q    <= req_we_i;
                        data_addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        data_be_q    <= be_d;
                        data_wdata_q <= wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            rsp_rd_q    <= req_rd_i;
                        end else begin
                            data_req_q <= 1'b1;
                            state_q    <= LSU_REQ;
                        end
`else
                        data_req_q <= 1'b1;
                        state_q    <= LSU_REQ;
`endif
                    end
                end
                LSU_REQ: begin
                    if (data_gnt_i) begin
                        data_req_q <= 1'b0;
                        state_q    <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (data_rvalid_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= data_we_q ? 32'd0 : rdata_d;
                        rsp_rd_q    <= rd_q;
                        state_q     <= LSU_IDLE;
                    end
                end
                default: begin
                    state_q    <= LSU_IDLE;
                    data_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = idle;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_rd_o     = rsp_rd_q;
    assign data_req_o   = data_req_q;
    assign data_we_o    = data_we_q;
    assign data_addr_o  = data_addr_q;
    assign data_be_o    = data_be_q;
    assign data_wdata_o = data_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign rsp_err_o    = rsp_err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with randomized bus timing
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rdd;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   last_rsp = 0;
    bit   bus_auto = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'((w >> (8 * k)) & 32'hff);
    endfunction

    // Reference model: bytes covered, lane placement and extension computed byte by byte.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                  input logic [4:0] rd, input int gd, input int rdd);
        int   n, off;
        bit   mis;
        bus_t b;
        rsp_t r;
        logic [31:0] v, m;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (int'(a[1:0]) % n) != 0;
        r.rd = rd; r.err = 1'b0; r.data = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            r.err = 1'b1;
            rsp_q.push_back(r);
            return;
        end
`endif
        off = (int'(a[1:0]) / n) * n;
        b.addr = a & 32'hFFFF_FFFC;
        b.be = 4'b0000;
        for (int i = 0; i < n; i++) b.be[off + i] = 1'b1;
        b.wdata = 32'd0;
        for (int j = 0; j < 4; j++) b.wdata = b.wdata | (32'(byte_of(wd, j % n)) << (8 * j));
        b.we = we; b.rdata = rdat; b.gd = gd; b.rdd = rdd;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(byte_of(rdat, off + i)) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) begin
            m = (32'd1 << (8 * n)) - 32'd1;
            v = v | ~m;
        end
        r.data = we ? 32'd0 : v;
        bus_q.push_back(b);
        rsp_q.push_back(r);
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd,
                         input int gd, input int rdd, input bit push);
        bit ok;
        ok = 1'b0;
        if (push) model(we, sz, uns, a, wd, rdat, rd, gd, rdd);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
        req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (req_ready_o) begin
                ok = 1'b1;
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (bus_q.size() == 0 && rsp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(rsp_q.size()), 32'd0);
        #1;
    endtask

    // Bus responder: checks the held payload every request cycle, then grants and answers.
    initial begin : bus_resp
        bus_t b;
        int   reqc;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_auto && data_req_o) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", 32'd1, 32'd0);
                end else begin
                    b = bus_q.pop_front();
                    reqc = 0;
                    for (int i = 0; i <= b.gd; i++) begin
                        if (i > 0) @(negedge clk);
                        if (data_req_o) reqc++;
                        chk("bus_addr", data_addr_o, b.addr);
                        chk("bus_be", 32'(data_be_o), 32'(b.be));
                        chk("bus_we", 32'(data_we_o), 32'(b.we));
                        if (b.we) chk("bus_wdata", data_wdata_o, b.wdata);
                    end
                    chk("req_hold_cycles", 32'(reqc), 32'(b.gd + 1));
                    data_gnt_i = 1'b1;
                    @(negedge clk);
                    data_gnt_i = 1'b0;
                    chk("req_drop_after_gnt", 32'(data_req_o), 32'd0);
                    repeat (b.rdd) @(negedge clk);
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = b.rdata;
                    @(negedge clk);
                    data_rvalid_i = 1'b0;
                    data_rdata_i  = $urandom;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the unit pulses a response.
    initial begin : rsp_mon
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_valid_o) begin
                last_rsp = cyc;
                chk("ready_in_rsp_cycle", 32'(req_ready_o), 32'd1);
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata_o, r.data);
                    chk("rsp_rd", 32'(rsp_rd_o), 32'(r.rd));
                    chk("rsp_err", 32'(rsp_err_o), 32'(r.err));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a1, a2;
        logic [1:0] sz;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; req_rd_i = 5'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_data_req", 32'(data_req_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_rd", 32'(rsp_rd_o), 32'd0);
        chk("rst_data_addr", data_addr_o, 32'd0);
        chk("rst_data_be", 32'(data_be_o), 32'd0);
        chk("rst_data_wdata", data_wdata_o, 32'd0);
        chk("rst_data_we", 32'(data_we_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 5'd1, 0, 0, 1'b1);
        a1 = last_acc;
        wait_idle();
        chk("lw_latency", 32'(last_rsp - a1), 32'd3);

        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80FFFFFF, 5'd2, 0, 0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80FFFFFF, 5'd3, 1, 1, 1'b1);
        wait_idle();
        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h55555555, 5'd4, 3, 0, 1'b1);
        wait_idle();
        issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 32'h11223344, 5'd5, 0, 0, 1'b1);
        wait_idle();

        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 32'hA5A5A5A5, 5'd6, 0, 0, 1'b1);
        a1 = last_acc;
        issue(1'b0, 2'b01, 1'b0, 32'h406, 32'd0, 32'h8001F00F, 5'd7, 0, 0, 1'b1);
        a2 = last_acc;
        wait_idle();
        chk("b2b_accept_in_rsp_cycle", 32'(a2 - a1), 32'd3);
        chk("b2b_second_latency", 32'(last_rsp - a2), 32'd3);

        bus_auto = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 32'd0, 5'd8, 0, 0, 1'b0);
        @(negedge clk);
        chk("rstwait_req_seen", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstwait_data_req", 32'(data_req_o), 32'd0);
        chk("rstwait_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFEF00D;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstwait_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rstwait_idle", 32'(req_ready_o), 32'd1);
        chk("rstwait_req_low", 32'(data_req_o), 32'd0);
        bus_auto = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 150; k++) begin
            sz = 2'($urandom_range(0, 3));
            issue(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
                  5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
